riscv_wb_arbiter: RTL and testbench
===================================

Name: riscv_wb_arbiter

Overview:
Write-side master for the 64-bit integer register file. It merges two writeback sources into the single RF write port (regwrite/rdaddr/rddata). The sources are a fast in-order pipe (ALU/load, no backpressure) and a slow long-latency unit (mul/div, valid/ready), which is buffered in a small FIFO. It also keeps a per-register pending scoreboard so decode can stall on outstanding slow destinations.

Parameters:
XLEN, 64, data width of writeback values
DEPTH, 4, slow-result FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles a non-empty FIFO may go undrained before o_riscv_wbarb_fast_stall asserts

Ports:
i_riscv_wbarb_clk  in  1  clock; all state updates on posedge
i_riscv_wbarb_rst_n  in  1  reset, asynchronous, active-low
i_riscv_wbarb_fast_valid  in  1  fast-pipe writeback valid
i_riscv_wbarb_fast_rdaddr  in  5  fast destination
i_riscv_wbarb_fast_rddata  in  XLEN  fast result
i_riscv_wbarb_slow_valid  in  1  slow-unit result valid
i_riscv_wbarb_slow_rdaddr  in  5  slow destination
i_riscv_wbarb_slow_rddata  in  XLEN  slow result
o_riscv_wbarb_slow_ready  out  1  FIFO can accept
i_riscv_wbarb_issue_valid  in  1  slow op issued this cycle
i_riscv_wbarb_issue_rdaddr  in  5  its destination
o_riscv_wbarb_regwrite  out  1  RF write enable (registered)
o_riscv_wbarb_rdaddr  out  5  RF write address (registered)
o_riscv_wbarb_rddata  out  XLEN  RF write data (registered)
o_riscv_wbarb_pending  out  32  bit r = slow result for xr outstanding
o_riscv_wbarb_fast_stall  out  1  request upstream to bubble fast pipe
o_riscv_wbarb_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): regwrite=0, rdaddr=0, rddata=0, pending=0, fast_stall=0, count=0, FIFO flushed, starve counter=0. slow_ready=1, since it follows count=0. Reset mid-operation discards all buffered results and clears the scoreboard.
- Output timing: outputs are registered on posedge so they are stable before the RF's negedge write in the same cycle.
- Fast path: fast_valid && fast_rdaddr!=0 at edge N gives regwrite=1 with that addr/data during cycle N+1 (1-cycle latency). fast_rdaddr=0 is dropped (regwrite=0).
- Slow handshake: enqueue when slow_valid && slow_ready. slow_ready = (count<DEPTH) and does not credit a same-cycle pop. Entries with rdaddr=0 are accepted but not enqueued.
- Slow source hold rule: valid, addr and data must remain stable while ready=0.
- No enqueue-to-output bypass: earliest regwrite for a slow result is 2 cycles after the handshake.
- Arbitration per edge:
  - If a fast write is valid (rd!=0), the fast write goes out.
  - Otherwise, if count>0, pop the FIFO head to the output.
  - Otherwise regwrite=0.
  - Fast always wins. Push and pop in the same cycle leave count unchanged.
- Starvation:
  - The counter increments each edge that count>0 and no pop occurs. It clears on a pop or when empty.
  - When it reaches STARVE_MAX, fast_stall=1 (registered) until the next pop.
  - Upstream must hold fast_valid=0 while stall=1. If it does not, fast still wins.
- Scoreboard:
  - issue_valid && issue_rdaddr!=0 sets pending[rd].
  - A slow pop clears pending[rd] at the same edge regwrite asserts.
  - Same-edge set and clear of the same bit: set wins.
  - pending[0] is always 0.
  - Upstream guarantees no second slow issue to a register already pending, and no fast write to a pending register.
- FIFO order: strictly FIFO; pointers wrap modulo DEPTH.

Test Plan:
- Reset then idle: regwrite=0, pending=0, slow_ready=1, count=0. Assert rst_n=0 mid-burst: all cleared immediately, no clock needed.
- Fast x5=0xDEAD at edge 1: regwrite=1, rdaddr=5, rddata=0xDEAD in cycle 2. Fast x0=0x1 gives regwrite=0.
- Issue rd=7, then slow x7=0x1234 with no fast traffic: pending[7]=1 after issue; regwrite with x7=0x1234 two cycles after the handshake; pending[7]=0 at that same edge.
- Fast valid every cycle while slow pushes 4 results: count reaches 4 and slow_ready=0. fast_stall=1 after 8 undrained cycles. A bubble pops the oldest entry, count=3, and in-order drain follows.
- Simultaneous fast x3 and slow-head x9 eligible: x3 written first, x9 next free cycle.
- Issue rd=9 at the same edge pending[9] is cleared by a pop: pending[9] stays 1.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: the write-side master for the 64-bit integer register file.
// It merges two writeback sources into the single RF write port:
//   - fast in-order pipe (ALU/load), which has no backpressure and always wins arbitration;
//   - slow long-latency unit (mul/div), which uses a valid/ready handshake and is buffered
//     in a DEPTH-entry FIFO.
// It also keeps a per-register pending scoreboard of outstanding slow destinations.
//
// Ports:
//   i_riscv_wbarb_clk / i_riscv_wbarb_rst_n : clock, async active-low reset
//   i_riscv_wbarb_fast_*                    : fast writeback (valid, rdaddr, rddata)
//   i_riscv_wbarb_slow_* / o_..._slow_ready : slow result handshake into the FIFO
//   i_riscv_wbarb_issue_*                   : slow op issued (sets pending bit)
//   o_riscv_wbarb_regwrite/rdaddr/rddata    : registered RF write port
//   o_riscv_wbarb_pending                   : bit r set while a slow result for xr is outstanding
//   o_riscv_wbarb_fast_stall                : asks upstream to bubble the fast pipe
//   o_riscv_wbarb_count                     : FIFO occupancy
module riscv_wb_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     i_riscv_wbarb_clk,
  input  logic                     i_riscv_wbarb_rst_n,
  input  logic                     i_riscv_wbarb_fast_valid,
  input  logic [4:0]               i_riscv_wbarb_fast_rdaddr,
  input  logic [XLEN-1:0]          i_riscv_wbarb_fast_rddata,
  input  logic                     i_riscv_wbarb_slow_valid,
  input  logic [4:0]               i_riscv_wbarb_slow_rdaddr,
  input  logic [XLEN-1:0]          i_riscv_wbarb_slow_rddata,
  output logic                     o_riscv_wbarb_slow_ready,
  input  logic                     i_riscv_wbarb_issue_valid,
  input  logic [4:0]               i_riscv_wbarb_issue_rdaddr,
  output logic                     o_riscv_wbarb_regwrite,
  output logic [4:0]               o_riscv_wbarb_rdaddr,
  output logic [XLEN-1:0]          o_riscv_wbarb_rddata,
  output logic [31:0]              o_riscv_wbarb_pending,
  output logic                     o_riscv_wbarb_fast_stall,
  output logic [$clog2(DEPTH):0]   o_riscv_wbarb_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StvW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] DepthC     = CntW'(DEPTH);
  localparam logic [StvW-1:0] StarveMaxC = StvW'(STARVE_MAX);

  // FIFO storage carries no reset; pointers and count define what is valid.
  logic [4:0]      fifo_addr_q [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StvW-1:0] starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rdaddr_q, rdaddr_d;
  logic [XLEN-1:0] rddata_q, rddata_d;
  logic [31:0]     pending_q, pending_d;

  logic            fast_go, slow_ready, push, pop;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;

  assign fast_go    = i_riscv_wbarb_fast_valid && (i_riscv_wbarb_fast_rdaddr != 5'd0);
  // Ready looks only at current occupancy; a same-cycle pop is not credited.
  assign slow_ready = (count_q < DepthC);
  // x0 results are acknowledged but never stored.
  assign push       = i_riscv_wbarb_slow_valid && slow_ready && (i_riscv_wbarb_slow_rdaddr != 5'd0);
  // Pop only from registered occupancy, so a fresh push cannot bypass to the output.
  assign pop        = !fast_go && (count_q != '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    regwrite_d = 1'b0;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    pending_d  = pending_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (fast_go) begin
      regwrite_d = 1'b1;
      rdaddr_d   = i_riscv_wbarb_fast_rdaddr;
      rddata_d   = i_riscv_wbarb_fast_rddata;
    end else if (pop) begin
      regwrite_d = 1'b1;
      rdaddr_d   = head_addr;
      rddata_d   = head_data;
      pending_d[head_addr] = 1'b0;
    end

    // Applied after the pop clear so a same-edge set wins.
    if (i_riscv_wbarb_issue_valid) pending_d[i_riscv_wbarb_issue_rdaddr] = 1'b1;
    pending_d[0] = 1'b0;

    // Saturating count of edges with buffered data that did not drain.
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (starve_q != StarveMaxC) begin
      starve_d = starve_q + StvW'(1);
    end
    stall_d = (starve_d == StarveMaxC);
  end

  always_ff @(posedge i_riscv_wbarb_clk or negedge i_riscv_wbarb_rst_n) begin
    if (!i_riscv_wbarb_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
      pending_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
      pending_q  <= pending_d;
    end
  end

  always_ff @(posedge i_riscv_wbarb_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_riscv_wbarb_slow_rdaddr;
      fifo_data_q[wr_ptr_q] <= i_riscv_wbarb_slow_rddata;
    end
  end

  assign o_riscv_wbarb_slow_ready = slow_ready;
  assign o_riscv_wbarb_regwrite   = regwrite_q;
  assign o_riscv_wbarb_rdaddr     = rdaddr_q;
  assign o_riscv_wbarb_rddata     = rddata_q;
  assign o_riscv_wbarb_pending    = pending_q;
  assign o_riscv_wbarb_fast_stall = stall_q;
  assign o_riscv_wbarb_count      = count_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: a hand-derived vector table, hand-written multi-cycle sequences
// (FIFO fill/starvation, async reset mid-burst) and a randomized run against a queue-based model.
module tb_riscv_wb_arbiter;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            fv, sv, iv;
  logic [4:0]      fa, sa, ia;
  logic [XLEN-1:0] fd, sd;
  logic            ready, we, stall;
  logic [4:0]      addr;
  logic [XLEN-1:0] data;
  logic [31:0]     pend;
  logic [2:0]      cnt;

  riscv_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .i_riscv_wbarb_clk        (clk),
    .i_riscv_wbarb_rst_n      (rst_n),
    .i_riscv_wbarb_fast_valid (fv),
    .i_riscv_wbarb_fast_rdaddr(fa),
    .i_riscv_wbarb_fast_rddata(fd),
    .i_riscv_wbarb_slow_valid (sv),
    .i_riscv_wbarb_slow_rdaddr(sa),
    .i_riscv_wbarb_slow_rddata(sd),
    .o_riscv_wbarb_slow_ready (ready),
    .i_riscv_wbarb_issue_valid(iv),
    .i_riscv_wbarb_issue_rdaddr(ia),
    .o_riscv_wbarb_regwrite   (we),
    .o_riscv_wbarb_rdaddr     (addr),
    .o_riscv_wbarb_rddata     (data),
    .o_riscv_wbarb_pending    (pend),
    .o_riscv_wbarb_fast_stall (stall),
    .o_riscv_wbarb_count      (cnt)
  );

  // Reference model: a queue of buffered results plus the visible output state.
  typedef struct packed {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;
  ent_t            q[$];
  logic [31:0]     m_pend;
  int              m_starve;
  logic            m_stall, m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic fv; logic [4:0] fa; logic [XLEN-1:0] fd;
    logic sv; logic [4:0] sa; logic [XLEN-1:0] sd;
    logic iv; logic [4:0] ia;
    logic we; logic [4:0] addr; logic [XLEN-1:0] data;
    int cnt; logic [31:0] pend;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = '0; m_starve = 0; m_stall = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic idle();
    fv = 1'b0; fa = '0; fd = '0; sv = 1'b0; sa = '0; sd = '0; iv = 1'b0; ia = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   fgo, psh, pp, had;
    ent_t h;
    fgo = fv && (fa != 0);
    psh = sv && (q.size() < DEPTH) && (sa != 0);
    had = q.size() > 0;
    pp  = !fgo && had;
    if (fgo) begin
      m_we = 1'b1; m_addr = fa; m_data = fd;
    end else if (pp) begin
      h = q.pop_front();
      m_we = 1'b1; m_addr = h.a; m_data = h.d; m_pend[h.a] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iv && ia != 0) m_pend[ia] = 1'b1;
    if (psh) q.push_back({sa, sd});
    if (had && !pp) begin
      if (m_starve < STARVE_MAX) m_starve++;
    end else begin
      m_starve = 0;
    end
    m_stall = (m_starve == STARVE_MAX);
  endtask

  task automatic check_model();
    chk("model_regwrite", we, m_we);
    if (m_we) begin
      chk("model_rdaddr", addr, m_addr);
      chk("model_rddata", data, m_data);
    end
    chk("model_pending", pend, m_pend);
    chk("model_stall", stall, m_stall);
    chk("model_count", cnt, 64'(q.size()));
    chk("model_ready", ready, q.size() < DEPTH);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_regwrite"}, we, 0);
    chk({tag, "_rdaddr"}, addr, 0);
    chk({tag, "_rddata"}, data, 0);
    chk({tag, "_pending"}, pend, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_ready"}, ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int prob[6];
    prob = '{30, 90, 50, 70, 20, 95};

    // fv fa fd | sv sa sd | iv ia | we addr data | cnt pend
    vt[0]  = '{1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 5'd5, 64'hDEAD, 0, 32'h0};
    vt[1]  = '{1'b1, 5'd0, 64'h1,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b0, 5'd0, 64'h0,    0, 32'h0};
    vt[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 1'b0, 5'd0, 64'h0,    0, 32'h80};
    vt[3]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 64'h0,    1, 32'h80};
    vt[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 5'd7, 64'h1234, 0, 32'h0};
    vt[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 1'b0, 5'd0, 64'h0,    0, 32'h200};
    vt[6]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 64'h99,   1'b0, 5'd0, 1'b0, 5'd0, 64'h0,    1, 32'h200};
    vt[7]  = '{1'b1, 5'd3, 64'h33,   1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 5'd3, 64'h33,   1, 32'h200};
    vt[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 1'b1, 5'd9, 64'h99,   0, 32'h200};
    vt[9]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 64'h77,   1'b0, 5'd0, 1'b0, 5'd0, 64'h0,    1, 32'h200};
    vt[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 1'b1, 5'd9, 64'h77,   0, 32'h0};

    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    cycle();

    // Table-driven directed vectors, one edge each, starting from an empty arbiter.
    for (int i = 0; i < 11; i++) begin
      fv = vt[i].fv; fa = vt[i].fa; fd = vt[i].fd;
      sv = vt[i].sv; sa = vt[i].sa; sd = vt[i].sd;
      iv = vt[i].iv; ia = vt[i].ia;
      cycle();
      chk($sformatf("vec%0d_regwrite", i), we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_rdaddr", i), addr, vt[i].addr);
        chk($sformatf("vec%0d_rddata", i), data, vt[i].data);
      end
      chk($sformatf("vec%0d_count", i), cnt, 64'(vt[i].cnt));
      chk($sformatf("vec%0d_pending", i), pend, vt[i].pend);
    end

    // Continuous fast traffic while the slow unit fills the FIFO: starvation then drain.
    for (int c = 0; c < 9; c++) begin
      fv = 1'b1; fa = 5'(1 + c % 3); fd = 64'(100 + c);
      sv = (c < 4); sa = 5'(10 + c); sd = 64'(32'hA0 + c);
      iv = 1'b0; ia = '0;
      cycle();
      if (c == 3) begin
        chk("fill_count", cnt, 4);
        chk("fill_ready", ready, 0);
      end
      if (c == 7) chk("starve_stall_early", stall, 0);
      if (c == 8) begin
        chk("starve_stall", stall, 1);
        chk("starve_count", cnt, 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      cycle();
      chk($sformatf("drain%0d_regwrite", k), we, 1);
      chk($sformatf("drain%0d_rdaddr", k), addr, 64'(10 + k));
      chk($sformatf("drain%0d_rddata", k), data, 64'(32'hA0 + k));
      chk($sformatf("drain%0d_count", k), cnt, 64'(3 - k));
      chk($sformatf("drain%0d_stall", k), stall, 0);
    end

    // Reset asserted between edges mid-burst must clear everything without a clock.
    for (int c = 0; c < 3; c++) begin
      fv = 1'b1; fa = 5'd4; fd = 64'(c);
      sv = 1'b1; sa = 5'(20 + c); sd = 64'(c + 7);
      iv = 1'b1; ia = 5'(20 + c);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic, phases vary the fast-pipe load to exercise starvation.
    for (int n = 0; n < 3000; n++) begin
      if (m_stall && $urandom_range(0, 9) != 0) begin
        fv = 1'b0;
      end else begin
        fv = $urandom_range(0, 99) < prob[n / 500];
      end
      fa = 5'($urandom_range(0, 31));
      if (m_pend[fa]) fa = 5'd0;
      fd = {$urandom, $urandom};
      // Slow source holds its offer while ready is low.
      if (!(sv && q.size() >= DEPTH)) begin
        sv = $urandom_range(0, 9) < 6;
        sa = 5'($urandom_range(0, 31));
        sd = {$urandom, $urandom};
      end
      iv = $urandom_range(0, 9) < 3;
      ia = 5'($urandom_range(0, 31));
      if (m_pend[ia]) iv = 1'b0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
